control_unit: RTL and testbench

//  Single-issue execute unit of the 8-bit microprocessor: decodes one 15-bit instruction per clock from
//  the program memory (registered read, addressed by the top-level program counter).
//  - executes it against an internal 8x8-bit register file.
//  - outputs a 9-bit result and 2 status flags.
//  - the top-level sequencer branches on flag[1] when the opcode is 0000.

---
 rtl/control_unit.sv | 130 +++++++++++++
 tb/tb_control_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Single-issue execute unit: decodes one 15-bit instruction per clk_cu edge against an 8x8 register file.
// Optional multiplier on opcode 1110 is enabled by defining CU_MUL_EN; otherwise 1110 is a NOP.
module control_unit #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8
) (
    input  logic              clk_cu,
    input  logic              rst_n,
    input  logic [14:0]       pgm_mem,
    output logic [DATA_W:0]   result,
    output logic [1:0]        flag
);

    // state      | meaning
    // halted_q=0 | executing one instruction per edge
    // halted_q=1 | HALT seen; every instruction ignored until reset
    localparam logic [3:0] OP_BRZ  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_LDI  = 4'b1001;
    localparam logic [3:0] OP_MOV  = 4'b1010;
    localparam logic [3:0] OP_INC  = 4'b1011;
    localparam logic [3:0] OP_DEC  = 4'b1100;
    localparam logic [3:0] OP_CMP  = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W:0]   result_q, result_d;
    logic [1:0]        flag_q, flag_d;
    logic              halted_q, halted_d;

    logic [3:0]        op;
    logic [2:0]        rd, rs1, rs2;
    logic [DATA_W-1:0] a, b, imm8;
    logic [DATA_W:0]   alu;
    logic              wr_en, upd_en;
`ifdef CU_MUL_EN
    logic [2*DATA_W-1:0] prod;
`endif

    assign op   = pgm_mem[14:11];
    assign rd   = pgm_mem[10:8];
    assign rs1  = pgm_mem[7:5];
    assign rs2  = pgm_mem[4:2];
    assign imm8 = pgm_mem[7:0];
    assign a    = regs_q[rs1];
    assign b    = regs_q[rs2];
`ifdef CU_MUL_EN
    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

    always_comb begin
        alu      = '0;
        wr_en    = 1'b0;
        upd_en   = 1'b0;
        halted_d = halted_q;
        if (!halted_q) begin
            wr_en  = 1'b1;
            upd_en = 1'b1;
            case (op)
                OP_ADD:  alu = {1'b0, a} + {1'b0, b};
                OP_SUB:  alu = {1'b0, a} - {1'b0, b};
                OP_AND:  alu = {1'b0, a & b};
                OP_OR:   alu = {1'b0, a | b};
                OP_XOR:  alu = {1'b0, a ^ b};
                OP_NOT:  alu = {1'b0, ~a};
                OP_SHL:  alu = {a, 1'b0};
                OP_SHR:  alu = {a[0], 1'b0, a[DATA_W-1:1]};
                OP_LDI:  alu = {1'b0, imm8};
                OP_MOV:  alu = {1'b0, a};
                OP_INC:  alu = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
                OP_DEC:  alu = {1'b0, a} - {{DATA_W{1'b0}}, 1'b1};
                OP_CMP: begin
                    alu   = {1'b0, a} - {1'b0, b};
                    wr_en = 1'b0;
                end
`ifdef CU_MUL_EN
                OP_MUL:  alu = {|prod[2*DATA_W-1:DATA_W], prod[DATA_W-1:0]};
`endif
                OP_HALT: begin
                    halted_d = 1'b1;
                    wr_en    = 1'b0;
                    upd_en   = 1'b0;
                end
                default: begin
                    // BRZ, and NOP when the multiplier is not built
                    wr_en  = 1'b0;
                    upd_en = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        regs_d   = regs_q;
        result_d = result_q;
        flag_d   = flag_q;
        if (wr_en) regs_d[rd] = alu[DATA_W-1:0];
        if (upd_en) begin
            result_d = alu;
            flag_d   = {~|alu[DATA_W-1:0], alu[DATA_W]};
        end
    end

    always_ff @(posedge clk_cu or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            result_q <= '0;
            flag_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            halted_q <= halted_d;
        end
    end

    assign result = result_q;
    assign flag   = flag_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random instruction streams
// compared against an arithmetic reference model. Define CU_MUL_EN to test the multiplier build.
module tb_control_unit;

    logic        clk_cu;
    logic        rst_n;
    logic [14:0] pgm_mem;
    logic [8:0]  result;
    logic [1:0]  flag;

    int checks = 0;
    int errors = 0;

    int m_r [8];
    int m_res;
    int m_flag;
    bit m_halt;

    control_unit dut (
        .clk_cu  (clk_cu),
        .rst_n   (rst_n),
        .pgm_mem (pgm_mem),
        .result  (result),
        .flag    (flag)
    );

    initial clk_cu = 1'b0;
    always #5 clk_cu = ~clk_cu;

    function automatic logic [14:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
        logic [14:0] w;
        w = {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], 2'b00};
        return w;
    endfunction

    function automatic logic [14:0] enc_i(input int op, input int rd, input int imm);
        logic [14:0] w;
        w = {op[3:0], rd[2:0], imm[7:0]};
        return w;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_res  = 0;
        m_flag = 0;
        m_halt = 0;
    endfunction

    // Reference semantics written from the opcode table with integer arithmetic.
    function automatic void model_exec(input logic [14:0] ins);
        int op, rd, a, b, s, c, v;
        bit wr;
        op = int'(ins[14:11]);
        rd = int'(ins[10:8]);
        a  = m_r[int'(ins[7:5])];
        b  = m_r[int'(ins[4:2])];
        wr = 1;
        if (m_halt) return;
        case (op)
            0:  return;
            1:  begin v = a + b; s = v % 256; c = (v > 255); end
            2:  begin s = (a - b + 256) % 256; c = (a < b); end
            3:  begin s = a & b; c = 0; end
            4:  begin s = a | b; c = 0; end
            5:  begin s = a ^ b; c = 0; end
            6:  begin s = 255 - a; c = 0; end
            7:  begin s = (a * 2) % 256; c = a / 128; end
            8:  begin s = a / 2; c = a % 2; end
            9:  begin s = int'(ins[7:0]); c = 0; end
            10: begin s = a; c = 0; end
            11: begin v = a + 1; s = v % 256; c = (v > 255); end
            12: begin s = (a + 255) % 256; c = (a == 0); end
            13: begin s = (a - b + 256) % 256; c = (a < b); wr = 0; end
`ifdef CU_MUL_EN
            14: begin v = a * b; s = v % 256; c = (v > 255); end
`else
            14: return;
`endif
            default: begin m_halt = 1; return; end
        endcase
        if (wr) m_r[rd] = s;
        m_res  = c * 256 + s;
        m_flag = (s == 0 ? 2 : 0) + c;
    endfunction

    task automatic step(input logic [14:0] ins);
        @(negedge clk_cu);
        pgm_mem = ins;
        model_exec(ins);
        @(posedge clk_cu);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_cu);
        pgm_mem = 15'h0000;
        rst_n   = 1'b0;
        @(negedge clk_cu);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        step(enc_i(9, 1, 8'h81));
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 9'h000 || flag !== 2'b00) begin
            errors++;
            $display("FAIL reset_async result=%h flag=%b expected 000/00", result, flag);
        end
        @(negedge clk_cu);
        pgm_mem = 15'h0000;
        rst_n   = 1'b1;
        model_reset();
        step(enc_r(10, 2, 1, 0));
        checks++;
        if (result !== 9'h000 || flag !== 2'b10) begin
            errors++;
            $display("FAIL reset_regs_cleared result=%h flag=%b expected 000/10", result, flag);
        end
    endtask

    task automatic test_load_add();
        step(enc_i(9, 1, 8'hFF));
        step(enc_i(9, 2, 8'h01));
        step(enc_r(1, 3, 1, 2));
        checks++;
        if (result !== 9'h100 || flag !== 2'b11) begin
            errors++;
            $display("FAIL add_wrap result=%h flag=%b expected 100/11", result, flag);
        end
        step(enc_r(10, 4, 3, 0));
        checks++;
        if (result !== 9'h000 || flag !== 2'b10) begin
            errors++;
            $display("FAIL mov_zero result=%h flag=%b expected 000/10", result, flag);
        end
    endtask

    task automatic test_sub_cmp();
        step(enc_i(9, 1, 8'h05));
        step(enc_i(9, 2, 8'h07));
        step(enc_r(2, 3, 1, 2));
        checks++;
        if (result !== 9'h1FE || flag !== 2'b01) begin
            errors++;
            $display("FAIL sub_borrow result=%h flag=%b expected 1fe/01", result, flag);
        end
        step(enc_r(13, 3, 1, 1));
        checks++;
        if (result !== 9'h000 || flag !== 2'b10) begin
            errors++;
            $display("FAIL cmp_equal result=%h flag=%b expected 000/10", result, flag);
        end
        step(enc_r(10, 5, 3, 0));
        checks++;
        if (result !== 9'h0FE || flag !== 2'b00) begin
            errors++;
            $display("FAIL cmp_no_write result=%h flag=%b expected 0fe/00", result, flag);
        end
    endtask

    task automatic test_shift_logic();
        step(enc_i(9, 1, 8'h81));
        step(enc_r(7, 2, 1, 0));
        checks++;
        if (result !== 9'h102 || flag !== 2'b01) begin
            errors++;
            $display("FAIL shl result=%h flag=%b expected 102/01", result, flag);
        end
        step(enc_r(8, 2, 1, 0));
        checks++;
        if (result !== 9'h140 || flag !== 2'b01) begin
            errors++;
            $display("FAIL shr result=%h flag=%b expected 140/01", result, flag);
        end
        step(enc_r(5, 3, 1, 1));
        checks++;
        if (result !== 9'h000 || flag !== 2'b10) begin
            errors++;
            $display("FAIL xor_self result=%h flag=%b expected 000/10", result, flag);
        end
        step(enc_i(9, 0, 8'h00));
        step(enc_r(12, 6, 0, 0));
        checks++;
        if (result !== 9'h1FF || flag !== 2'b01) begin
            errors++;
            $display("FAIL dec_zero result=%h flag=%b expected 1ff/01", result, flag);
        end
    endtask

    task automatic test_hold_halt();
        step(enc_r(5, 3, 1, 1));
        step(enc_i(0, 0, 8'hF8));
        checks++;
        if (result !== 9'h000 || flag !== 2'b10) begin
            errors++;
            $display("FAIL brz_hold result=%h flag=%b expected 000/10", result, flag);
        end
`ifndef CU_MUL_EN
        step(enc_r(14, 3, 1, 1));
        checks++;
        if (result !== 9'h000 || flag !== 2'b10) begin
            errors++;
            $display("FAIL nop_hold result=%h flag=%b expected 000/10", result, flag);
        end
`endif
        step(enc_r(15, 0, 0, 0));
        step(enc_i(9, 1, 8'h33));
        checks++;
        if (result !== 9'h000 || flag !== 2'b10) begin
            errors++;
            $display("FAIL halt_ignore result=%h flag=%b expected 000/10", result, flag);
        end
        do_reset();
        step(enc_i(9, 1, 8'h33));
        checks++;
        if (result !== 9'h033 || flag !== 2'b00) begin
            errors++;
            $display("FAIL ldi_after_reset result=%h flag=%b expected 033/00", result, flag);
        end
    endtask

    task automatic test_mul();
        step(enc_i(9, 1, 8'h10));
        step(enc_i(9, 2, 8'h10));
        step(enc_r(14, 3, 1, 2));
`ifdef CU_MUL_EN
        checks++;
        if (result !== 9'h100 || flag !== 2'b11) begin
            errors++;
            $display("FAIL mul_overflow result=%h flag=%b expected 100/11", result, flag);
        end
`else
        checks++;
        if (result !== 9'h010 || flag !== 2'b00) begin
            errors++;
            $display("FAIL mul_as_nop result=%h flag=%b expected 010/00", result, flag);
        end
`endif
        step(enc_i(9, 1, 8'h03));
        step(enc_i(9, 2, 8'h05));
        step(enc_r(14, 3, 1, 2));
`ifdef CU_MUL_EN
        checks++;
        if (result !== 9'h00F || flag !== 2'b00) begin
            errors++;
            $display("FAIL mul_small result=%h flag=%b expected 00f/00", result, flag);
        end
`else
        checks++;
        if (result !== 9'h005 || flag !== 2'b00) begin
            errors++;
            $display("FAIL mul_small_nop result=%h flag=%b expected 005/00", result, flag);
        end
`endif
    endtask

    task automatic test_random();
        logic [14:0] ins;
        int halt_cycles;
        halt_cycles = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            ins = 15'($urandom);
            if ($urandom_range(0, 39) == 0) ins[14:11] = 4'hF;
            else ins[14:11] = 4'($urandom_range(0, 14));
            step(ins);
            checks++;
            if (result !== 9'(m_res) || flag !== 2'(m_flag)) begin
                errors++;
                $display("FAIL random n=%0d ins=%h result=%h flag=%b expected %h/%b",
                         n, ins, result, flag, 9'(m_res), 2'(m_flag));
            end
            if (m_halt) halt_cycles++;
            if (halt_cycles > 4) begin
                halt_cycles = 0;
                do_reset();
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        pgm_mem = 15'h0000;
        model_reset();
        #12;
        checks++;
        if (result !== 9'h000 || flag !== 2'b00) begin
            errors++;
            $display("FAIL reset_initial result=%h flag=%b expected 000/00", result, flag);
        end
        @(negedge clk_cu);
        rst_n = 1'b1;
        test_reset();
        test_load_add();
        test_sub_cmp();
        test_shift_logic();
        test_hold_halt();
        test_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
